ram_banked: RTL and testbench
=============================

Name: ram_banked

Overview:
- Parametrised, multi-bank successor to the 4-bit data RAM in the TB4004 core.
- Provides BANKS independent synchronous RAM banks behind a registered bank-select latch, which models the 4004 DCL command-line selection.
- Adds a selectable read-during-write mode, a read-valid strobe, and a hardware clear engine that zero-fills all banks after reset or on request.
- Sits between the execute stage (RAM/WRM/RDM/SBM/ADM datapath) and the memory fabric.

Parameters:
- DATA_W, 4: word width in bits.
- ADDR_W, 12: address width per bank; depth per bank is 2**ADDR_W.
- BANKS, 8: number of banks, ≥1; BANK_W = max(1, clog2(BANKS)).
- WRITE_FIRST, 1: 1 means a read colliding with a write returns the new data; 0 means it returns the old data.

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  synchronous, active-low reset.
- bankLd  in  1  load the bank-select latch from bankSel.
- bankSel  in  BANK_W  new bank index.
- ramWe  in  1  write strobe.
- ramRe  in  1  read strobe.
- addr  in  ADDR_W  word address within the current bank.
- dataIn  in  DATA_W  write data.
- clrReq  in  1  one-cycle pulse that starts a full zero-fill.
- dataOut  out  DATA_W  registered read data.
- rdValid  out  1  dataOut was updated by an accepted read this cycle.
- busy  out  1  clear engine active; accesses are ignored.
- curBank  out  BANK_W  current value of the bank latch.
- parityErr  out  1  present only under RAM_PARITY_EN; tied to 0 otherwise.

Behaviour:
- Reset (rstN=0 at a clk edge):
  - dataOut=0, rdValid=0, curBank=0, parityErr=0.
  - FSM goes to CLEAR with the sweep counter at 0, so busy=1 in the first cycle after reset.
  - Memory contents are not reset directly; the CLEAR sweep zeroes them.
- FSM states: IDLE, CLEAR.
  - CLEAR: each cycle writes 0 to the word {bank=cnt[high], addr=cnt[low]}, then increments cnt.
  - CLEAR exits to IDLE after the last word (BANKS·2**ADDR_W − 1) is written, i.e. after exactly BANKS·2**ADDR_W cycles; busy drops in the cycle after the last write.
  - IDLE goes to CLEAR on clrReq=1; cnt reloads to 0. clrReq asserted while already in CLEAR restarts the sweep from 0.
  - A reset asserted mid-sweep restarts the sweep from 0.
- Bank latch:
  - bankLd=1 loads curBank←bankSel at the clk edge. The latch updates even while busy.
  - An access in the same cycle as bankLd uses the old curBank.
  - bankSel ≥ BANKS saturates to BANKS−1.
- Access (IDLE only):
  - Write: ramWe=1 writes mem[curBank][addr]←dataIn.
  - Read: ramRe=1 gives dataOut←mem[curBank][addr] with one-cycle latency and pulses rdValid=1 for one cycle.
  - ramWe=1 together with ramRe=1: the write always happens. dataOut is dataIn when WRITE_FIRST=1, or the old content when WRITE_FIRST=0. rdValid=1.
  - ramWe=1 with ramRe=0: dataOut holds its value and rdValid=0.
  - No strobe: dataOut holds and rdValid=0.
- While busy: ramWe and ramRe are ignored (no write, no read), dataOut holds, and rdValid=0.
- Addresses always wrap modulo 2**ADDR_W; there is no out-of-range case.

Optional Feature:
- Macro: RAM_PARITY_EN.
- When defined:
  - Each word stores an extra even-parity bit computed on write; CLEAR writes parity 0.
  - On an accepted read, parityErr pulses 1 for one cycle alongside rdValid if the stored parity mismatches.
  - A write-first bypass read never flags an error.
- When undefined: no parity storage, and parityErr is held at 0.

Decomposition:
- Shared package tb4004_mem_pkg holds:
  - the FSM state enum (ST_IDLE, ST_CLEAR);
  - the BANK_W derivation function;
  - default width constants, shared with the ROM and register-file blocks.
- Natural sub-module: ram_bank_array, one synchronous single-port array per bank with registered output and a WRITE_FIRST parameter.
- ram_banked instantiates BANKS copies of ram_bank_array and muxes their outputs by the registered bank index.

Test Plan:
- Use small parameters (ADDR_W=4, BANKS=2) for speed.
1. Reset, then poll → busy=1 for exactly 32 cycles, then 0. Reading every address in both banks returns 0 with rdValid=1.
2. bankLd with bankSel=1; write addr 3←0xA; bankLd with bankSel=0; read addr 3 → 0x0. Switch back to bank 1 and read addr 3 → 0xA one cycle after ramRe.
3. mem[0][5]=0x3, then ramWe=ramRe=1 at addr 5 with dataIn=0xC. WRITE_FIRST=1 gives dataOut=0xC; WRITE_FIRST=0 gives dataOut=0x3. In both cases a following read returns 0xC.
4. Write 0xF to addr 2. Pulse clrReq; attempt a write of 0x7 during busy → ignored, rdValid stays 0. After busy drops, read addr 2 → 0x0.
5. Pulse rstN=0 midway through a CLEAR sweep → busy stays 1 for the full 32 cycles counted from the reset release; curBank reads 0.
6. With RAM_PARITY_EN, force a parity-bit flip on mem[1][4] and read it → parityErr=1 coincident with rdValid. A clean read gives parityErr=0.

Source files
------------

// File: rtl/tb4004_mem_pkg.sv
// -----------------------------------------------------------------------------
// tb4004_mem_pkg
// Shared definitions for the TB4004 memory blocks (data RAM, ROM, register
// file): default width constants, the clear-engine FSM state encoding and the
// bank-index width derivation.
// -----------------------------------------------------------------------------
package tb4004_mem_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_BANKS  = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } mem_state_t;

    // Width of a bank index; never narrower than one bit so a single-bank
    // build still has a legal curBank port.
    function automatic int bank_w(input int banks);
        int w;
        w = $clog2(banks);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ram_bank_array.sv
// -----------------------------------------------------------------------------
// ram_bank_array
// One synchronous single-port RAM bank with a registered read port.
//
// Parameters:
//   W           stored word width (data plus optional parity bit)
//   ADDR_W      address width, depth = 2**ADDR_W
//   WRITE_FIRST 1: a read colliding with a write returns the write data
//               0: it returns the previous contents
// Ports:
//   clk    rising-edge clock
//   rstN   synchronous active-low reset of the read register only
//   we     write enable
//   re     read enable; rdata updates only when re=1, otherwise holds
//   addr   word address
//   wdata  write data
//   rdata  registered read data
// -----------------------------------------------------------------------------
module ram_bank_array #(
    parameter int W           = 4,
    parameter int ADDR_W      = 12,
    parameter int WRITE_FIRST = 1
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [2**ADDR_W];

    // Storage has no reset; the owner's clear engine zero-fills it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            rdata <= '0;
        end else if (re) begin
            if (we && (WRITE_FIRST != 0)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ram_banked.sv
// -----------------------------------------------------------------------------
// ram_banked
// Multi-bank 4004-style data RAM: BANKS synchronous banks behind a registered
// bank-select latch (DCL model), a read-valid strobe and a clear engine that
// zero-fills every word after reset or on clrReq.
//
// Optional feature macro: RAM_PARITY_EN (per-word even parity, parityErr).
//
// Ports:
//   clk        rising-edge clock
//   rstN       synchronous active-low reset
//   bankLd     load curBank from bankSel (saturated to BANKS-1), even while busy
//   bankSel    new bank index
//   ramWe      write strobe
//   ramRe      read strobe
//   addr       word address within curBank
//   dataIn     write data
//   clrReq     start (or restart) a full zero-fill sweep
//   dataOut    registered read data, holds between reads
//   rdValid    one-cycle pulse: dataOut was updated by an accepted read
//   busy       clear sweep in progress
//   curBank    current bank latch value
//   parityErr  stored parity mismatch on the read reported by rdValid
//
// Strobe semantics: ramWe/ramRe are single-cycle requests accepted only when
// busy=0; there is no back-pressure. An accepted read presents its data on
// dataOut together with rdValid=1 exactly one cycle later. Requests made while
// busy=1 are dropped silently. The access in a cycle carrying bankLd uses the
// bank latched before that edge.
// -----------------------------------------------------------------------------
module ram_banked
    import tb4004_mem_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int BANKS       = DEF_BANKS,
    parameter int WRITE_FIRST = 1,
    localparam int BANK_W     = bank_w(BANKS)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              bankLd,
    input  logic [BANK_W-1:0] bankSel,
    input  logic              ramWe,
    input  logic              ramRe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              clrReq,
    output logic [DATA_W-1:0] dataOut,
    output logic              rdValid,
    output logic              busy,
    output logic [BANK_W-1:0] curBank,
    output logic              parityErr
);

`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam int CNT_W = BANK_W + ADDR_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BANKS * (2 ** ADDR_W) - 1);

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [BANK_W-1:0] rd_bank_q;
`ifdef RAM_PARITY_EN
    logic              rd_bypass_q;
`endif

    logic [BANK_W-1:0] clr_bank;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] bank_addr;
    logic [MEM_W-1:0]  bank_wdata;
    logic [BANKS-1:0]  bank_we;
    logic [BANKS-1:0]  bank_re;
    logic [MEM_W-1:0]  bank_rdata [BANKS];
    logic [MEM_W-1:0]  rd_word;
    logic              acc_en;

    assign busy     = (state == ST_CLEAR);
    assign acc_en   = (state == ST_IDLE);
    assign clr_bank = cnt[CNT_W-1:ADDR_W];
    assign clr_addr = cnt[ADDR_W-1:0];

    // The sweep owns the address/data buses while busy.
    assign bank_addr = busy ? clr_addr : addr;
`ifdef RAM_PARITY_EN
    // Stored parity bit makes the whole word even; all-zero words are clean.
    assign bank_wdata = busy ? '0 : {^dataIn, dataIn};
`else
    assign bank_wdata = busy ? '0 : dataIn;
`endif

    for (genvar i = 0; i < BANKS; i++) begin : g_bank
        assign bank_we[i] = busy ? (clr_bank == BANK_W'(i))
                                 : (ramWe && (curBank == BANK_W'(i)));
        assign bank_re[i] = acc_en && ramRe && (curBank == BANK_W'(i));

        ram_bank_array #(
            .W          (MEM_W),
            .ADDR_W     (ADDR_W),
            .WRITE_FIRST(WRITE_FIRST)
        ) u_bank (
            .clk  (clk),
            .rstN (rstN),
            .we   (bank_we[i]),
            .re   (bank_re[i]),
            .addr (bank_addr),
            .wdata(bank_wdata),
            .rdata(bank_rdata[i])
        );
    end

    // Each bank holds its own last read word, so selecting by the bank that
    // served the most recent read keeps dataOut stable across bank switches.
    assign rd_word = bank_rdata[rd_bank_q];
    assign dataOut = rd_word[DATA_W-1:0];

`ifdef RAM_PARITY_EN
    assign parityErr = rdValid && !rd_bypass_q && (^rd_word);
`else
    assign parityErr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state     <= ST_CLEAR;
            cnt       <= '0;
            curBank   <= '0;
            rdValid   <= 1'b0;
            rd_bank_q <= '0;
`ifdef RAM_PARITY_EN
            rd_bypass_q <= 1'b0;
`endif
        end else begin
            if (bankLd) begin
                if (int'(bankSel) >= BANKS) begin
                    curBank <= BANK_W'(BANKS - 1);
                end else begin
                    curBank <= bankSel;
                end
            end

            rdValid <= 1'b0;
            if (acc_en && ramRe) begin
                rdValid   <= 1'b1;
                rd_bank_q <= curBank;
`ifdef RAM_PARITY_EN
                rd_bypass_q <= ramWe && (WRITE_FIRST != 0);
`endif
            end

            case (state)
                ST_IDLE: begin
                    if (clrReq) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clrReq) begin
                        cnt <= '0;
                    end else if (cnt == LAST_CNT) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_banked.sv
// -----------------------------------------------------------------------------
// tb_ram_banked
// Directed bench for ram_banked with ADDR_W=4, BANKS=2. Two instances share
// every input: dut_a is write-first, dut_b is read-first.
// -----------------------------------------------------------------------------
module tb_ram_banked;

    localparam int DATA_W  = 4;
    localparam int ADDR_W  = 4;
    localparam int BANKS   = 2;
    localparam int BANK_W  = 1;
    localparam int CLR_CYC = BANKS * (1 << ADDR_W);

    logic              clk;
    logic              rstN;
    logic              bankLd;
    logic [BANK_W-1:0] bankSel;
    logic              ramWe;
    logic              ramRe;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dataIn;
    logic              clrReq;

    logic [DATA_W-1:0] dataOut_a, dataOut_b;
    logic              rdValid_a, rdValid_b;
    logic              busy_a, busy_b;
    logic [BANK_W-1:0] curBank_a, curBank_b;
    logic              parityErr_a, parityErr_b;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    ram_banked #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANKS(BANKS), .WRITE_FIRST(1)) dut_a (
        .clk(clk), .rstN(rstN), .bankLd(bankLd), .bankSel(bankSel), .ramWe(ramWe),
        .ramRe(ramRe), .addr(addr), .dataIn(dataIn), .clrReq(clrReq),
        .dataOut(dataOut_a), .rdValid(rdValid_a), .busy(busy_a), .curBank(curBank_a),
        .parityErr(parityErr_a)
    );

    ram_banked #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANKS(BANKS), .WRITE_FIRST(0)) dut_b (
        .clk(clk), .rstN(rstN), .bankLd(bankLd), .bankSel(bankSel), .ramWe(ramWe),
        .ramRe(ramRe), .addr(addr), .dataIn(dataIn), .clrReq(clrReq),
        .dataOut(dataOut_b), .rdValid(rdValid_b), .busy(busy_b), .curBank(curBank_b),
        .parityErr(parityErr_b)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank(input logic [BANK_W-1:0] b);
        bankLd = 1'b1; bankSel = b;
        step();
        bankLd = 1'b0;
        check("cur_bank_a", 32'(curBank_a), 32'(b));
        check("cur_bank_b", 32'(curBank_b), 32'(b));
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ramWe = 1'b1; addr = a; dataIn = d;
        step();
        ramWe = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] exp, input logic exp_perr);
        ramRe = 1'b1; addr = a;
        step();
        ramRe = 1'b0;
        check({tag, "_data_a"}, 32'(dataOut_a), 32'(exp));
        check({tag, "_data_b"}, 32'(dataOut_b), 32'(exp));
        check({tag, "_valid_a"}, 32'(rdValid_a), 32'd1);
        check({tag, "_valid_b"}, 32'(rdValid_b), 32'd1);
        check({tag, "_perr_a"}, 32'(parityErr_a), 32'(exp_perr));
    endtask

    // Called at the sample point right after the edge that starts a sweep.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (busy_a === 1'b1 && n < 200) begin
            n++;
            step();
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(CLR_CYC));
        check({tag, "_busy_b_low"}, 32'(busy_b), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rstN = 1'b0; bankLd = 1'b0; bankSel = '0; ramWe = 1'b0; ramRe = 1'b0;
        addr = '0; dataIn = '0; clrReq = 1'b0;
        step();
        step();
        check("rst_data", 32'(dataOut_a), 32'd0);
        check("rst_valid", 32'(rdValid_a), 32'd0);
        check("rst_bank", 32'(curBank_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd1);
        check("rst_perr", 32'(parityErr_a), 32'd0);
        rstN = 1'b1;

        // 1: power-up sweep length, then every word reads as zero
        wait_clear("t1");
        for (int b = 0; b < BANKS; b++) begin
            load_bank(BANK_W'(b));
            for (int a = 0; a < (1 << ADDR_W); a++) begin
                read_check("t1_rd", ADDR_W'(a), 4'h0, 1'b0);
            end
        end

        // 2: bank isolation and switching
        load_bank(1'b1);
        write_word(4'd3, 4'hA);
        load_bank(1'b0);
        read_check("t2_b0", 4'd3, 4'h0, 1'b0);
        load_bank(1'b1);
        read_check("t2_b1", 4'd3, 4'hA, 1'b0);
        step();
        check("t2_valid_drop", 32'(rdValid_a), 32'd0);
        check("t2_data_hold", 32'(dataOut_a), 32'hA);
        // write in the bankLd cycle goes to the old bank (1)
        bankLd = 1'b1; bankSel = 1'b0; ramWe = 1'b1; addr = 4'd7; dataIn = 4'h5;
        step();
        bankLd = 1'b0; ramWe = 1'b0;
        check("t2_ld_bank", 32'(curBank_a), 32'd0);
        read_check("t2_old_b0", 4'd7, 4'h0, 1'b0);
        load_bank(1'b1);
        read_check("t2_old_b1", 4'd7, 4'h5, 1'b0);

        // 3: read-during-write
        load_bank(1'b0);
        write_word(4'd5, 4'h3);
        ramWe = 1'b1; ramRe = 1'b1; addr = 4'd5; dataIn = 4'hC;
        step();
        ramWe = 1'b0; ramRe = 1'b0;
        check("t3_wf_data", 32'(dataOut_a), 32'hC);
        check("t3_rf_data", 32'(dataOut_b), 32'h3);
        check("t3_wf_valid", 32'(rdValid_a), 32'd1);
        check("t3_rf_valid", 32'(rdValid_b), 32'd1);
        check("t3_wf_perr", 32'(parityErr_a), 32'd0);
        read_check("t3_after", 4'd5, 4'hC, 1'b0);
        // write without read: dataOut holds, no valid
        write_word(4'd6, 4'h9);
        check("t3_wo_hold", 32'(dataOut_a), 32'hC);
        check("t3_wo_valid", 32'(rdValid_a), 32'd0);

        // 4: clear request; accesses during busy are dropped
        write_word(4'd2, 4'hF);
        clrReq = 1'b1;
        step();
        clrReq = 1'b0;
        check("t4_busy", 32'(busy_a), 32'd1);
        ramWe = 1'b1; ramRe = 1'b1; addr = 4'd2; dataIn = 4'h7;
        step();
        ramWe = 1'b0; ramRe = 1'b0;
        check("t4_busy_valid", 32'(rdValid_a), 32'd0);
        check("t4_busy_hold_a", 32'(dataOut_a), 32'hC);
        check("t4_busy_hold_b", 32'(dataOut_b), 32'hC);
        // restart: clrReq while sweeping reloads the counter
        for (int i = 0; i < 8; i++) step();
        clrReq = 1'b1;
        step();
        clrReq = 1'b0;
        wait_clear("t4");
        read_check("t4_rd2", 4'd2, 4'h0, 1'b0);
        read_check("t4_rd6", 4'd6, 4'h0, 1'b0);

        // 5: reset in the middle of a sweep; bank latch loads while busy
        clrReq = 1'b1;
        step();
        clrReq = 1'b0;
        for (int i = 0; i < 10; i++) step();
        load_bank(1'b1);
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        check("t5_bank", 32'(curBank_a), 32'd0);
        check("t5_busy", 32'(busy_a), 32'd1);
        wait_clear("t5");
        check("t5_bank_after", 32'(curBank_a), 32'd0);

`ifdef RAM_PARITY_EN
        // 6: corrupted parity bit is reported on the read
        load_bank(1'b1);
        write_word(4'd4, 4'h6);
        write_word(4'd8, 4'h6);
        dut_a.g_bank[1].u_bank.mem[4] = dut_a.g_bank[1].u_bank.mem[4] ^ 5'h10;
        read_check("t6_bad", 4'd4, 4'h6, 1'b1);
        read_check("t6_clean", 4'd8, 4'h6, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
